// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter that shares one non-stalling FPU pipeline between NUM_REQ requesters.
// Optional per-requester perf counters are compiled in when FPU_ISSUE_PERF_EN is defined.
module fpu_issue_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int FPU_LATENCY  = 6,
    parameter int MAX_INFLIGHT = 7,
    parameter int DATA_W       = 32
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]           req_op1,
    input  logic [NUM_REQ*DATA_W-1:0]           req_op2,
    input  logic [NUM_REQ*2-1:0]                req_operation,
    input  logic                                drain,
    output logic [DATA_W-1:0]                   fpu_operand1,
    output logic [DATA_W-1:0]                   fpu_operand2,
    output logic [1:0]                          fpu_operation,
    input  logic [DATA_W-1:0]                   fpu_result,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_W-1:0]                   rsp_result,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                                idle
`ifdef FPU_ISSUE_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]               perf_issue_cnt,
    output logic [15:0]                         perf_stall_cnt
`endif
);

    localparam int TOTAL = FPU_LATENCY + 1;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [PTR_W-1:0]   lastGrant;
    logic [PTR_W-1:0]   winner;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic               canIssue;
    logic               accept;
    logic               retire;
    int                 scanIdx;

    logic [TOTAL-1:0]   tagValid;
    logic [PTR_W-1:0]   tagId [TOTAL];

    // Credit check uses only registered state, so a returning response never frees a slot in the same cycle.
    assign canIssue = RST_N && !drain && (inflight < MAX_CNT);
    assign eligible = req_valid & {NUM_REQ{canIssue}};

    always_comb begin
        grant   = '0;
        winner  = lastGrant;
        found   = 1'b0;
        scanIdx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scanIdx = (int'(lastGrant) + k) % NUM_REQ;
            if (!found && eligible[scanIdx]) begin
                found          = 1'b1;
                grant[scanIdx] = 1'b1;
                winner         = PTR_W'(scanIdx);
            end
        end
    end

    assign accept     = |grant;
    assign retire     = tagValid[TOTAL-1];
    assign req_ready  = grant;
    assign rsp_result = fpu_result;
    assign idle       = (inflight == '0) && !accept;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fpu_operand1  <= '0;
            fpu_operand2  <= '0;
            fpu_operation <= '0;
            lastGrant     <= PTR_W'(NUM_REQ - 1);
            tagValid      <= '0;
            for (int k = 0; k < TOTAL; k++) tagId[k] <= '0;
            rsp_valid     <= '0;
            inflight      <= '0;
        end else begin
            if (accept) begin
                fpu_operand1  <= req_op1[int'(winner)*DATA_W +: DATA_W];
                fpu_operand2  <= req_op2[int'(winner)*DATA_W +: DATA_W];
                fpu_operation <= req_operation[int'(winner)*2 +: 2];
                lastGrant     <= winner;
            end else begin
                fpu_operand1  <= '0;
                fpu_operand2  <= '0;
                fpu_operation <= '0;
            end

            tagValid <= {tagValid[TOTAL-2:0], accept};
            tagId[0] <= accept ? winner : '0;
            for (int k = 1; k < TOTAL; k++) tagId[k] <= tagId[k-1];

            // The last tag stage lines up with the FPU result one cycle later, hence the registered strobe.
            rsp_valid <= retire ? (NUM_REQ'(1) << tagId[TOTAL-1]) : '0;

            case ({accept, retire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef FPU_ISSUE_PERF_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) perf_issue_cnt[i*16 +: 16] <= perf_issue_cnt[i*16 +: 16] + 16'd1;
            end
            if ((|req_valid) && !accept) perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

    inflightBound: assert property (@(posedge CLK) disable iff (!RST_N) (inflight <= MAX_CNT));
    inflightFloor: assert property (@(posedge CLK) disable iff (!RST_N)
                                    !((inflight == '0) && retire && !accept));

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter: default instance plus a MAX_INFLIGHT=3 instance for throttling.
module tb_fpu_issue_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;

    logic                        CLK;
    logic                        RST_N;
    logic [NUM_REQ-1:0]          reqValid;
    logic [NUM_REQ-1:0]          reqReady;
    logic [NUM_REQ*DATA_W-1:0]   reqOp1;
    logic [NUM_REQ*DATA_W-1:0]   reqOp2;
    logic [NUM_REQ*2-1:0]        reqOperation;
    logic                        drain;
    logic [DATA_W-1:0]           fpuOperand1;
    logic [DATA_W-1:0]           fpuOperand2;
    logic [1:0]                  fpuOperation;
    logic [DATA_W-1:0]           fpuResult;
    logic [NUM_REQ-1:0]          rspValid;
    logic [DATA_W-1:0]           rspResult;
    logic [2:0]                  inflight;
    logic                        idle;

    logic [NUM_REQ-1:0]          reqValidT;
    logic [NUM_REQ-1:0]          reqReadyT;
    logic [DATA_W-1:0]           fpuOperand1T;
    logic [DATA_W-1:0]           fpuOperand2T;
    logic [1:0]                  fpuOperationT;
    logic [NUM_REQ-1:0]          rspValidT;
    logic [DATA_W-1:0]           rspResultT;
    logic [1:0]                  inflightT;
    logic                        idleT;

`ifdef FPU_ISSUE_PERF_EN
    logic [NUM_REQ*16-1:0]       perfIssueCnt;
    logic [15:0]                 perfStallCnt;
    logic [NUM_REQ*16-1:0]       perfIssueCntT;
    logic [15:0]                 perfStallCntT;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    fpu_issue_arbiter #(.NUM_REQ(2), .FPU_LATENCY(6), .MAX_INFLIGHT(7), .DATA_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(reqValid), .req_ready(reqReady),
        .req_op1(reqOp1), .req_op2(reqOp2), .req_operation(reqOperation),
        .drain(drain),
        .fpu_operand1(fpuOperand1), .fpu_operand2(fpuOperand2), .fpu_operation(fpuOperation),
        .fpu_result(fpuResult),
        .rsp_valid(rspValid), .rsp_result(rspResult),
        .inflight(inflight), .idle(idle)
`ifdef FPU_ISSUE_PERF_EN
        , .perf_issue_cnt(perfIssueCnt), .perf_stall_cnt(perfStallCnt)
`endif
    );

    fpu_issue_arbiter #(.NUM_REQ(2), .FPU_LATENCY(6), .MAX_INFLIGHT(3), .DATA_W(32)) dutThrottle (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(reqValidT), .req_ready(reqReadyT),
        .req_op1(reqOp1), .req_op2(reqOp2), .req_operation(reqOperation),
        .drain(1'b0),
        .fpu_operand1(fpuOperand1T), .fpu_operand2(fpuOperand2T), .fpu_operation(fpuOperationT),
        .fpu_result(fpuResult),
        .rsp_valid(rspValidT), .rsp_result(rspResultT),
        .inflight(inflightT), .idle(idleT)
`ifdef FPU_ISSUE_PERF_EN
        , .perf_issue_cnt(perfIssueCntT), .perf_stall_cnt(perfStallCntT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // FPU stand-in: result changes every cycle so a registered pass-through would be caught.
    always @(negedge CLK) begin
        cyc       = cyc + 1;
        fpuResult = 32'hC0DE_0000 | 32'(cyc);
    end

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        reqValid  = '0;
        reqValidT = '0;
        drain     = 1'b0;
        RST_N     = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    int lat;
    int rspCount;
    int lastRspCyc;
    logic [1:0] expRsp;
    logic expReady;

    initial begin
        fpuResult    = '0;
        reqOp1       = '0;
        reqOp2       = '0;
        reqOperation = '0;
        drain        = 1'b0;
        reqValidT    = '0;
        reqValid     = 2'b01;
        RST_N        = 1'b0;

        // Reset state, with a request pending to show ready is held low
        tick();
        tick();
        checkEq("rst_ready", reqReady, 2'b00);
        checkEq("rst_idle", idle, 1'b1);
        checkEq("rst_op1", fpuOperand1, 32'h0);
        checkEq("rst_opn", fpuOperation, 2'b00);
        checkEq("rst_inflight", inflight, 3'd0);
        checkEq("rst_rsp", rspValid, 2'b00);
        reqValid = '0;
        RST_N    = 1'b1;
        tick();

        // Single issue
        reqOp1[31:0]      = 32'h3F80_0000;
        reqOp2[31:0]      = 32'h4000_0000;
        reqOperation[1:0] = 2'b00;
        reqValid          = 2'b01;
        #1;
        checkEq("single_ready", reqReady, 2'b01);
        checkEq("single_idle_busy", idle, 1'b0);
        tick();
        reqValid = '0;
        checkEq("single_op1", fpuOperand1, 32'h3F80_0000);
        checkEq("single_op2", fpuOperand2, 32'h4000_0000);
        checkEq("single_opn", fpuOperation, 2'b00);
        checkEq("single_inflight", inflight, 3'd1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) checkEq("single_bubble", fpuOperand1, 32'h0);
            if (rspValid != '0) begin
                lat = n;
                break;
            end
        end
        checkEq("single_latency", 64'(lat), 64'd7);
        checkEq("single_rsp", rspValid, 2'b01);
        checkEq("single_result", rspResult, fpuResult);
        checkEq("single_inflight_done", inflight, 3'd0);
        tick();
        checkEq("single_rsp_pulse", rspValid, 2'b00);
        checkEq("single_idle", idle, 1'b1);

        // Fairness: both requesters valid continuously
        doReset();
        reqOp1       = {32'h2222_2222, 32'h1111_1111};
        reqOperation = {2'b10, 2'b01};
        reqValid     = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkEq("fair_grant", reqReady, (i % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            checkEq("fair_op1", fpuOperand1, (i % 2 == 1) ? 32'h2222_2222 : 32'h1111_1111);
            checkEq("fair_opn", fpuOperation, (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        reqValid = '0;
        checkEq("fair_inflight", inflight, 3'd6);
        for (int j = 0; j < 8; j++) begin
            tick();
            expRsp = (j == 0 || j == 7) ? 2'b00 : ((j % 2 == 1) ? 2'b01 : 2'b10);
            checkEq("fair_rsp", rspValid, expRsp);
            if (j == 1) checkEq("fair_result", rspResult, fpuResult);
        end

        // Throttle on the MAX_INFLIGHT=3 instance
        doReset();
        reqValidT = 2'b01;
        for (int n = -1; n <= 11; n++) begin
            #1;
            expReady = (n <= 1) || (n >= 7 && n <= 9);
            checkEq("throttle_ready", reqReadyT, {1'b0, expReady});
            if (n == 2) checkEq("throttle_inflight", inflightT, 2'd3);
            tick();
        end
        reqValidT = '0;

        // Drain with four in flight
        doReset();
        reqOp1   = {32'h2222_2222, 32'h1111_1111};
        reqValid = 2'b01;
        for (int n = 0; n < 4; n++) tick();
        drain = 1'b1;
        #1;
        checkEq("drain_ready", reqReady, 2'b00);
        checkEq("drain_inflight", inflight, 3'd4);
        checkEq("drain_idle_busy", idle, 1'b0);
        rspCount   = 0;
        lastRspCyc = 0;
        for (int c = 4; c <= 11; c++) begin
            tick();
            if (reqReady != '0) checkEq("drain_ready_hold", reqReady, 2'b00);
            if (rspValid[0]) begin
                rspCount++;
                lastRspCyc = c;
            end
        end
        checkEq("drain_rsp_count", 64'(rspCount), 64'd4);
        checkEq("drain_last_rsp", 64'(lastRspCyc), 64'd10);
        checkEq("drain_idle", idle, 1'b1);
        checkEq("drain_inflight_done", inflight, 3'd0);
        drain    = 1'b0;
        reqValid = '0;

        // Reset mid-flight
        doReset();
        reqValid = 2'b11;
        for (int n = 0; n < 5; n++) tick();
        checkEq("midrst_inflight_pre", inflight, 3'd5);
        RST_N = 1'b0;
        #1;
        checkEq("midrst_inflight", inflight, 3'd0);
        checkEq("midrst_ready", reqReady, 2'b00);
        checkEq("midrst_idle", idle, 1'b1);
        checkEq("midrst_op1", fpuOperand1, 32'h0);
        tick();
        tick();
        reqValid = '0;
        RST_N    = 1'b1;
        rspCount = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (rspValid != '0) rspCount++;
        end
        checkEq("midrst_no_rsp", 64'(rspCount), 64'd0);
        checkEq("midrst_inflight_post", inflight, 3'd0);
        reqValid = 2'b11;
        #1;
        checkEq("midrst_first_grant", reqReady, 2'b01);
        tick();
        reqValid = '0;

`ifdef FPU_ISSUE_PERF_EN
        // Perf counters: 10 req0 accepts then 3 stalled cycles under drain
        doReset();
        for (int n = 0; n < 10; n++) begin
            reqValid = 2'b01;
            tick();
            reqValid = 2'b00;
            tick();
        end
        drain    = 1'b1;
        reqValid = 2'b01;
        for (int n = 0; n < 3; n++) tick();
        drain    = 1'b0;
        reqValid = 2'b00;
        tick();
        checkEq("perf_issue0", perfIssueCnt[15:0], 16'd10);
        checkEq("perf_issue1", perfIssueCnt[31:16], 16'd0);
        checkEq("perf_stall", perfStallCnt, 16'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
